// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl
//   Decode-stage branch controller for a 5-stage MIPS pipeline. It watches the
//   D-stage branch comparator operands for hazards against E/M producers and
//   selects comparator forwarding sources. It stalls F/D and bubbles E until the
//   operands are valid, then commits the comparator result as the PC redirect.
//   It also tracks the branch delay slot and keeps saturating statistics.
//
// Ports
//   clk, resetn            clock, asynchronous active-low reset
//   branchD, usesrtD       D holds a conditional branch / branch compares rt
//   rsD, rtD, cmp_y        D operands and comparator result
//   regwriteE/memtoregE/writeregE   E-stage producer
//   regwriteM/memtoregM/writeregM   M-stage producer
//   regwriteW/writeregW             W-stage producer
//   stallD_ext, flushD_ext external D freeze / exception flush
//   forwardAD, forwardBD   comparator source select (00 rf, 01 M ALU, 10 W)
//   stallF, stallD, flushE hazard stall / bubble controls
//   pcsrcD                 take branch target
//   in_dslotD              D holds a delay-slot instruction
//   branch_cnt, taken_cnt, stall_cnt  saturating statistics
module branch_resolve_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             branchD,
  input  logic             usesrtD,
  input  logic [4:0]       rsD,
  input  logic [4:0]       rtD,
  input  logic             cmp_y,
  input  logic             regwriteE,
  input  logic             memtoregE,
  input  logic [4:0]       writeregE,
  input  logic             regwriteM,
  input  logic             memtoregM,
  input  logic [4:0]       writeregM,
  input  logic             regwriteW,
  input  logic [4:0]       writeregW,
  input  logic             stallD_ext,
  input  logic             flushD_ext,
  output logic [1:0]       forwardAD,
  output logic [1:0]       forwardBD,
  output logic             stallF,
  output logic             stallD,
  output logic             flushE,
  output logic             pcsrcD,
  output logic             in_dslotD,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {StIdle, StWait, StDslot} state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic       rs_hz, rt_hz;
  logic       hazard;
  logic       resolve;
  logic       commit;
  logic       stall_inc;
  logic [1:0] fwd_a, fwd_b;

  // Any E-stage producer stalls a branch regardless of being a load: the
  // result is never ready for the D comparator in the same cycle. The load
  // flag only matters once the producer reaches M.
  logic unused_memtoreg_e;
  assign unused_memtoreg_e = memtoregE;

  // Hazard detection; register 0 never hazards.
  always_comb begin
    rs_hz = (rsD != 5'd0) &&
            ((regwriteE && (writeregE == rsD)) ||
             (regwriteM && memtoregM && (writeregM == rsD)));
    rt_hz = usesrtD && (rtD != 5'd0) &&
            ((regwriteE && (writeregE == rtD)) ||
             (regwriteM && memtoregM && (writeregM == rtD)));
    // A branch sitting in the delay slot is ignored entirely.
    hazard = branchD && (state_q != StDslot) && (rs_hz || rt_hz);
  end

  // Forwarding select; M non-load result beats W, register 0 never forwards.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (rsD != 5'd0) begin
      if (regwriteM && !memtoregM && (writeregM == rsD)) begin
        fwd_a = 2'b01;
      end else if (regwriteW && (writeregW == rsD)) begin
        fwd_a = 2'b10;
      end
    end
    if (usesrtD && (rtD != 5'd0)) begin
      if (regwriteM && !memtoregM && (writeregM == rtD)) begin
        fwd_b = 2'b01;
      end else if (regwriteW && (writeregW == rtD)) begin
        fwd_b = 2'b10;
      end
    end
  end

  // Resolve: the branch operands are valid this cycle and the comparator
  // result is presented as the redirect.
  always_comb begin
    resolve = 1'b0;
    if (!flushD_ext) begin
      unique case (state_q)
        StIdle:  resolve = branchD && !hazard;
        StWait:  resolve = !hazard;
        default: resolve = 1'b0;
      endcase
    end
    commit    = resolve && !stallD_ext;
    stall_inc = hazard && !stallD_ext && !flushD_ext;
  end

  // Next state.
  always_comb begin
    state_d = state_q;
    if (flushD_ext) begin
      state_d = StIdle;
    end else if (!stallD_ext) begin
      unique case (state_q)
        StIdle: begin
          if (branchD && hazard) begin
            state_d = StWait;
          end else if (resolve) begin
            state_d = StDslot;
          end
        end
        StWait: begin
          if (!hazard) begin
            state_d = StDslot;
          end
        end
        StDslot: state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Saturating statistics.
  always_comb begin
    branch_cnt_d = branch_cnt_q;
    taken_cnt_d  = taken_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (commit && (branch_cnt_q != '1)) begin
      branch_cnt_d = branch_cnt_q + CNT_W'(1);
    end
    if (commit && cmp_y && (taken_cnt_q != '1)) begin
      taken_cnt_d = taken_cnt_q + CNT_W'(1);
    end
    if (stall_inc && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      branch_cnt_q <= branch_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  // Combinational outputs are held at 0 while reset is asserted.
  always_comb begin
    forwardAD = (resetn && branchD) ? fwd_a : 2'b00;
    forwardBD = (resetn && branchD) ? fwd_b : 2'b00;
    stallF    = resetn && hazard && !flushD_ext;
    stallD    = resetn && hazard && !flushD_ext;
    flushE    = resetn && hazard && !flushD_ext;
    pcsrcD    = resetn && resolve && cmp_y;
    in_dslotD = resetn && (state_q == StDslot) && !flushD_ext;
  end

  assign branch_cnt = branch_cnt_q;
  assign taken_cnt  = taken_cnt_q;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
module tb_branch_resolve_ctrl;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             resetn;
  logic             branchD, usesrtD, cmp_y;
  logic [4:0]       rsD, rtD;
  logic             regwriteE, memtoregE, regwriteM, memtoregM, regwriteW;
  logic [4:0]       writeregE, writeregM, writeregW;
  logic             stallD_ext, flushD_ext;
  logic [1:0]       forwardAD, forwardBD;
  logic             stallF, stallD, flushE, pcsrcD, in_dslotD;
  logic [CNT_W-1:0] branch_cnt, taken_cnt, stall_cnt;

  int total = 0;
  int bad   = 0;

  branch_resolve_ctrl #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .branchD    (branchD),
    .usesrtD    (usesrtD),
    .rsD        (rsD),
    .rtD        (rtD),
    .cmp_y      (cmp_y),
    .regwriteE  (regwriteE),
    .memtoregE  (memtoregE),
    .writeregE  (writeregE),
    .regwriteM  (regwriteM),
    .memtoregM  (memtoregM),
    .writeregM  (writeregM),
    .regwriteW  (regwriteW),
    .writeregW  (writeregW),
    .stallD_ext (stallD_ext),
    .flushD_ext (flushD_ext),
    .forwardAD  (forwardAD),
    .forwardBD  (forwardBD),
    .stallF     (stallF),
    .stallD     (stallD),
    .flushE     (flushE),
    .pcsrcD     (pcsrcD),
    .in_dslotD  (in_dslotD),
    .branch_cnt (branch_cnt),
    .taken_cnt  (taken_cnt),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    branchD    = 1'b0;
    usesrtD    = 1'b0;
    cmp_y      = 1'b0;
    rsD        = 5'd0;
    rtD        = 5'd0;
    regwriteE  = 1'b0;
    memtoregE  = 1'b0;
    writeregE  = 5'd0;
    regwriteM  = 1'b0;
    memtoregM  = 1'b0;
    writeregM  = 5'd0;
    regwriteW  = 1'b0;
    writeregW  = 5'd0;
    stallD_ext = 1'b0;
    flushD_ext = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    resetn = 1'b0;
    #1;
    resetn = 1'b1;
    #1;
  endtask

  // Stall triple packed as {stallF, stallD, flushE}.
  function automatic logic [31:0] stalls();
    return 32'({stallF, stallD, flushE});
  endfunction

  initial begin
    // Reset holds every output at 0 even with a resolvable branch in D.
    clear_inputs();
    resetn  = 1'b0;
    branchD = 1'b1; cmp_y = 1'b1; rsD = 5'd1; rtD = 5'd2; usesrtD = 1'b1;
    regwriteM = 1'b1; writeregM = 5'd1;
    #2;
    chk("rst_outs", 32'({forwardAD, forwardBD, stallF, stallD, flushE, pcsrcD, in_dslotD}), 0);
    chk("rst_cnts", 32'({branch_cnt, taken_cnt, stall_cnt}), 0);

    // BEQ r1,r2 with no producers, taken.
    regwriteM = 1'b0;
    resetn = 1'b1;
    #1;
    chk("beq_pcsrc", 32'(pcsrcD), 1);
    chk("beq_stall", stalls(), 0);
    chk("beq_fwd", 32'({forwardAD, forwardBD}), 0);
    tick();
    branchD = 1'b0;
    #1;
    chk("beq_dslot", 32'(in_dslotD), 1);
    chk("beq_cnts", 32'({branch_cnt, taken_cnt}), 32'h11);
    // Branch with a hazard seen in the delay slot is ignored.
    branchD = 1'b1; cmp_y = 1'b1; regwriteE = 1'b1; writeregE = 5'd1;
    #1;
    chk("dslot_br_ign", 32'({stallD, pcsrcD, in_dslotD}), 32'b001);
    tick();
    clear_inputs();
    #1;
    chk("dslot_no_cnt", 32'({branch_cnt, taken_cnt, stall_cnt}), 32'h110);
    chk("dslot_left", 32'(in_dslotD), 0);

    // ADD r8 in E, then BEQ r8,r9 not taken.
    do_reset();
    regwriteE = 1'b1; writeregE = 5'd8;
    branchD = 1'b1; rsD = 5'd8; rtD = 5'd9; usesrtD = 1'b1; cmp_y = 1'b0;
    #1;
    chk("alu_stall", stalls(), 32'b111);
    chk("alu_pcsrc_w", 32'(pcsrcD), 0);
    tick();
    regwriteE = 1'b0; regwriteM = 1'b1; memtoregM = 1'b0; writeregM = 5'd8;
    #1;
    chk("alu_unstall", stalls(), 0);
    chk("alu_fwd", 32'({forwardAD, forwardBD}), 32'b0100);
    chk("alu_pcsrc", 32'(pcsrcD), 0);
    chk("alu_scnt", 32'(stall_cnt), 1);
    tick();
    clear_inputs();
    #1;
    chk("alu_dslot", 32'(in_dslotD), 1);
    chk("alu_cnts", 32'({branch_cnt, taken_cnt, stall_cnt}), 32'h101);
    tick();

    // LW r8 in E, then BNE r8,r0: two stall cycles, then forward from W.
    do_reset();
    regwriteE = 1'b1; memtoregE = 1'b1; writeregE = 5'd8;
    branchD = 1'b1; rsD = 5'd8; rtD = 5'd0; usesrtD = 1'b1; cmp_y = 1'b1;
    #1;
    chk("lw_stall1", stalls(), 32'b111);
    tick();
    regwriteE = 1'b0; memtoregE = 1'b0;
    regwriteM = 1'b1; memtoregM = 1'b1; writeregM = 5'd8;
    #1;
    chk("lw_stall2", stalls(), 32'b111);
    chk("lw_scnt1", 32'(stall_cnt), 1);
    tick();
    regwriteM = 1'b0; memtoregM = 1'b0; regwriteW = 1'b1; writeregW = 5'd8;
    #1;
    chk("lw_unstall", stalls(), 0);
    chk("lw_fwd", 32'({forwardAD, forwardBD}), 32'b1000);
    chk("lw_pcsrc", 32'(pcsrcD), 1);
    chk("lw_scnt2", 32'(stall_cnt), 2);
    tick();
    clear_inputs();
    #1;
    chk("lw_cnts", 32'({branch_cnt, taken_cnt, stall_cnt}), 32'h112);
    tick();

    // Register 0 never hazards; rt ignored when usesrtD=0.
    do_reset();
    branchD = 1'b1; rsD = 5'd0; usesrtD = 1'b0; regwriteE = 1'b1; writeregE = 5'd0;
    cmp_y = 1'b1;
    #1;
    chk("r0_nostall", stalls(), 0);
    chk("r0_pcsrc", 32'(pcsrcD), 1);
    tick();
    clear_inputs();
    tick();
    branchD = 1'b1; rsD = 5'd3; rtD = 5'd5; usesrtD = 1'b0;
    regwriteE = 1'b1; writeregE = 5'd5;
    regwriteM = 1'b1; memtoregM = 1'b0; writeregM = 5'd5;
    #1;
    chk("rt_unused_stall", stalls(), 0);
    chk("rt_unused_fwd", 32'({forwardAD, forwardBD}), 0);
    usesrtD = 1'b1;
    #1;
    chk("rt_used_stall", stalls(), 32'b111);
    chk("rt_used_fwd", 32'({forwardAD, forwardBD}), 32'b0001);
    clear_inputs();
    tick();

    // External stall freezes WAIT, then a flush returns to IDLE.
    do_reset();
    regwriteE = 1'b1; memtoregE = 1'b1; writeregE = 5'd8;
    branchD = 1'b1; rsD = 5'd8; cmp_y = 1'b1;
    tick();
    stallD_ext = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ext_stall_out", 32'(stallD), 1);
      chk("ext_stall_cnts", 32'({branch_cnt, stall_cnt}), 32'h01);
    end
    stallD_ext = 1'b0; flushD_ext = 1'b1;
    #1;
    chk("flush_stall", stalls(), 0);
    chk("flush_pcsrc", 32'(pcsrcD), 0);
    tick();
    clear_inputs();
    cmp_y = 1'b1;
    #1;
    chk("flush_idle", 32'(pcsrcD), 0);
    chk("flush_cnts", 32'({branch_cnt, stall_cnt}), 32'h01);
    // Flush during the delay slot masks in_dslotD.
    branchD = 1'b1;
    tick();
    branchD = 1'b0; flushD_ext = 1'b1;
    #1;
    chk("flush_dslot", 32'(in_dslotD), 0);
    tick();
    flushD_ext = 1'b0;
    #1;
    chk("flush_dslot_idle", 32'(in_dslotD), 0);

    // Saturation with a 4-bit counter build.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      branchD = 1'b1; cmp_y = 1'b1;
      tick();
      branchD = 1'b0;
      tick();
    end
    chk("sat_pre", 32'({branch_cnt, taken_cnt}), 32'hff);
    branchD = 1'b1; cmp_y = 1'b1;
    tick();
    branchD = 1'b0;
    tick();
    chk("sat_hold", 32'({branch_cnt, taken_cnt}), 32'hff);

    // Asynchronous reset mid-WAIT.
    regwriteE = 1'b1; writeregE = 5'd4;
    regwriteM = 1'b1; memtoregM = 1'b0; writeregM = 5'd4;
    branchD = 1'b1; rsD = 5'd4; cmp_y = 1'b1;
    tick();
    chk("wait_stall", 32'(stallD), 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_rst_outs",
        32'({forwardAD, forwardBD, stallF, stallD, flushE, pcsrcD, in_dslotD}), 0);
    chk("async_rst_cnts", 32'({branch_cnt, taken_cnt, stall_cnt}), 0);
    resetn = 1'b1;
    #1;
    chk("post_rst_stall", 32'(stallD), 1);
    clear_inputs();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
Decode-stage branch controller that sequences the D-stage branch comparator in the 5-stage MIPS pipeline. It detects operand hazards on the comparator inputs and selects forwarding sources. It stalls F/D and bubbles E until the operands are valid, then commits the comparator result as the PC redirect. It also tracks the branch delay slot and keeps saturating branch statistics.

Parameters:
CNT_W, 32, width of each statistics counter

Ports:
clk  in  1  pipeline clock
resetn  in  1  asynchronous active-low reset
branchD  in  1  instruction in D is a conditional branch (BEQ/BNE/BGTZ/BLEZ/REGIMM)
usesrtD  in  1  branch compares rt (BEQ/BNE); 0 = rs-only compare
rsD  in  5  rs of D instruction
rtD  in  5  rt of D instruction
cmp_y  in  1  comparator result for D instruction
regwriteE, memtoregE  in  1,1  E-stage write enable / load flag
writeregE  in  5  E-stage destination
regwriteM, memtoregM  in  1,1  M-stage write enable / load flag
writeregM  in  5  M-stage destination
regwriteW  in  1  W-stage write enable
writeregW  in  5  W-stage destination
stallD_ext  in  1  external freeze of D (memory wait)
flushD_ext  in  1  exception flush of D
forwardAD  out  2  comparator A source: 00 regfile, 01 M ALU result, 10 W result
forwardBD  out  2  comparator B source, same encoding
stallF, stallD  out  1,1  hazard stall of fetch/decode
flushE  out  1  inject bubble into E
pcsrcD  out  1  take branch target
in_dslotD  out  1  instruction in D is a delay slot
branch_cnt, taken_cnt, stall_cnt  out  CNT_W each  statistics

Behaviour:
- Sources: rs always. rt only if usesrtD. Register 0 never hazards and never forwards.
- hzE: regwriteE && writeregE==src. hzM_ld: regwriteM && memtoregM && writeregM==src.
- hazard = branchD && (hzE || hzM_ld) on any source, evaluated combinationally each cycle.
- Forward priority: M (non-load) -> 01, else W match -> 10, else 00. Forward outputs are driven whenever branchD=1, otherwise 00.
- Latency: ALU producer in E gives 1 stall cycle, then 01. Load in E gives 2 stall cycles, then 10. Load in M gives 1 stall cycle, then 10.
- stallF = stallD = flushE = hazard && !flushD_ext.
- FSM states: IDLE, WAIT, DSLOT. Reset state is IDLE.
  - IDLE: branchD && hazard -> WAIT. branchD && !hazard -> resolve, then DSLOT.
  - WAIT: hazard -> stay. !hazard -> resolve, then DSLOT.
  - DSLOT: in_dslotD=1. Leaves to IDLE on the first edge with !stallD_ext. A branchD seen in DSLOT is ignored: pcsrcD=0, no stall, no count.
- Resolve cycle: pcsrcD = cmp_y. pcsrcD is 0 in every other cycle.
- Commit: a resolve cycle with !stallD_ext.
  - At commit: branch_cnt+1, and taken_cnt+1 if cmp_y.
  - stall_cnt+1 on each edge where hazard && !stallD_ext && !flushD_ext.
  - All counters saturate at all-ones.
- stallD_ext=1: FSM holds state, counters hold, combinational outputs remain valid.
- flushD_ext=1 (priority over all):
  - stall/flushE/pcsrcD/in_dslotD forced 0 combinationally.
  - FSM -> IDLE next edge. No counter updates that cycle.
- Reset (asynchronous, any time, including mid-WAIT): state IDLE, all counters 0. All outputs 0 while resetn=0.

Test Plan:
- BEQ r1,r2, no producers, cmp_y=1 -> same cycle pcsrcD=1, stallD=0, forwardAD/BD=00. Next cycle in_dslotD=1. branch_cnt=1, taken_cnt=1.
- ADD r8 in E, then BEQ r8,r9, cmp_y=0 -> 1 cycle with stallF=stallD=flushE=1. Then forwardAD=01, pcsrcD=0. stall_cnt=1, branch_cnt=1, taken_cnt=0.
- LW r8 in E, then BNE r8,r0 (usesrtD=1) -> 2 stall cycles. Then forwardAD=10, forwardBD=00. stall_cnt=2.
- BGTZ r0 with regwriteE=1, writeregE=0 -> no stall. rt=r5 matching writeregE with usesrtD=0 -> no stall.
- LW in E with BEQ waiting: stallD_ext=1 for 3 cycles during WAIT -> state/counters frozen. Then flushD_ext=1 -> stall outputs 0 that cycle, state IDLE, branch_cnt unchanged.
- Counters preset near all-ones via 2^CNT_W-1 branches (CNT_W=4 build): a 16th taken branch leaves branch_cnt=taken_cnt=15. Drop resetn mid-WAIT -> outputs 0 immediately, counters 0.
